// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and request legality check for the load/store unit
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_e;

   function automatic logic req_error(input size_e size, input logic [31:0] addr,
                                      input logic [31:0] limit);
      logic bad;
      bad = (addr >= limit);
      case (size)
         SZ_H:    bad = bad | addr[0];
         SZ_W:    bad = bad | (|addr[1:0]);
         SZ_X:    bad = 1'b1;
         default: bad = bad;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request/response and data-memory port bundle for the load/store unit
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   // master = core plus memory environment, slave = the lsu itself
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - little-endian lane extract/extend for loads and lane merge for stores
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  size_e       size,
   input  logic        is_unsigned,
   input  logic [31:0] mem_word,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] lane_mask;
   logic [31:0] lane_data;
   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;

   always_comb begin
      byte_sh    = {addr_lo, 3'b000};
      half_sh    = {addr_lo[1], 4'b0000};
      shifted    = mem_word >> byte_sh;
      byte_sel   = shifted[7:0];
      half_sel   = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
      load_data  = mem_word;
      lane_mask  = 32'h0;
      lane_data  = 32'h0;
      case (size)
         SZ_B: begin
            load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            lane_mask = 32'h0000_00ff << byte_sh;
            lane_data = {24'h0, store_data[7:0]} << byte_sh;
         end
         SZ_H: begin
            load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            lane_mask = 32'h0000_ffff << half_sh;
            lane_data = {16'h0, store_data[15:0]} << half_sh;
         end
         SZ_W: begin
            lane_mask = 32'hffff_ffff;
            lane_data = store_data;
         end
         default: begin
            lane_mask = 32'h0;
         end
      endcase
      // untouched lanes pass through from the word just read
      merge_data = (mem_word & ~lane_mask) | (lane_data & lane_mask);
   end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store initiator: request FSM, read-modify-write for sub-word stores
module lsu
   import lsu_pkg::*;
#(
   parameter int WORDS = 256
) (
   input logic   clk,
   input logic   rst_n,
   lsu_if.slave  bus
);

   localparam logic [31:0] ADDR_LIMIT = 32'(WORDS * 4);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   size_e       size_q, size_d;
   logic        uns_q, uns_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] lane_load;
   logic [31:0] lane_merge;
   size_e       in_size;
   logic        in_err;

   lsu_lane u_lane (
      .addr_lo     (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .mem_word    (bus.mem_rdata),
      .store_data  (wdata_q),
      .load_data   (lane_load),
      .merge_data  (lane_merge)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= 32'h0;
         size_q  <= SZ_B;
         uns_q   <= 1'b0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         we_q    <= we_d;
         err_q   <= err_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      we_d    = we_q;
      err_d   = err_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      in_size = size_e'(bus.req_size);
      in_err  = req_error(in_size, bus.req_addr, ADDR_LIMIT);
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               addr_d  = bus.req_addr;
               size_d  = in_size;
               uns_d   = bus.req_unsigned;
               we_d    = bus.req_we;
               err_d   = in_err;
               wdata_d = bus.req_wdata;
               rdata_d = 32'h0;
               if (in_err)
                  state_d = RESP;
               else if (bus.req_we && in_size == SZ_W)
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD:   state_d = WAIT;
         WAIT: begin
            // mem_rdata is valid only in this cycle
            if (we_q) begin
               wdata_d = lane_merge;
               state_d = WR;
            end else begin
               rdata_d = lane_load;
               state_d = RESP;
            end
         end
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_err   = (state_q == RESP) & err_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.mem_en    = (state_q == RD) || (state_q == WR);
   assign bus.mem_we    = (state_q == WR);
   assign bus.mem_addr  = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata = wdata_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store initiator that drives the word-wide synchronous data-memory port on behalf of the core pipeline. It accepts one byte, halfword or word request at a time, issues the memory read and/or write, handles the memory's one-cycle read latency, and returns an extended load value or store completion. Sub-word stores are done as read-modify-write because the memory has only a whole-word write enable.

## Interface
- WORDS, 256: memory depth in 32-bit words; must match the attached memory. Byte addresses at or above WORDS*4 are errors.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle completion pulse; no backpressure
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  qualified by rsp_valid; misaligned, illegal size or out of range
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned byte address ({addr[31:2],2'b00})
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  memory read data, valid the cycle after a read with mem_en=1

## Operation
- Handshake: a request is accepted on a rising edge where req_valid & req_ready. All req_* fields are latched at acceptance and ignored afterwards.
- Error check at acceptance:
  - half with addr[0]=1
  - word with addr[1:0]≠0
  - size 11
  - addr ≥ WORDS*4
  - An errored request goes to RESP with rsp_err=1 and never asserts mem_en.
- FSM states:
  - IDLE → RD: load or sub-word store.
  - IDLE → WR: word store.
  - IDLE → RESP: error.
  - RD: mem_en=1, mem_we=0 → WAIT.
  - WAIT: mem_rdata valid.
    - Load: extract and extend into the result register → RESP.
    - Sub-word store: merge into the write-data register → WR.
  - WR: mem_en=1, mem_we=1 → RESP.
  - RESP: rsp_valid=1 → IDLE.
- Lanes are little-endian:
  - Byte k sits at [8k+7:8k] with k=addr[1:0].
  - The half sits at [16h+15:16h] with h=addr[1].
  - Word loads ignore req_unsigned.
- Merge replaces only the addressed lane(s). All other bits come unchanged from mem_rdata.
- mem_* outputs:
  - mem_en and mem_we are decoded from the state register only; there is no combinational path from req_* to mem_*.
  - mem_addr is held stable from RD through WR.
  - mem_wdata is held stable through WR.

## Timing
- Acceptance edge is T. rsp_valid is high in the cycle starting at:
  - load: T+3
  - word store: T+2
  - sub-word store: T+4 (mem_we high during the T+3 cycle only)
  - error: T+1
- Throughput: one request per 2–5 cycles. req_ready is low from T until RESP has passed.
- Reset values:
  - state IDLE, so req_ready=1 after the reset edge
  - rsp_valid, rsp_err, mem_en, mem_we all 0
  - rsp_rdata, mem_addr, mem_wdata all 0
- Reset mid-operation:
  - The block returns to IDLE at the reset edge and no response is issued.
  - A sub-word store reset before WR performs no write.
  - If the reset edge coincides with WR, the memory (which has no reset) still commits that write.
- req_valid while busy is ignored and not queued.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_X
  - the FSM state encoding (IDLE, RD, WAIT, WR, RESP)
- One combinational sub-module, lsu_lane, performs extract/extend (load) and lane merge (store) from addr[1:0], size and unsigned. The FSM and registers stay in lsu.

## Test plan
All scenarios use word 4 (byte address 0x10) preloaded to 0x8899AABB.
- Signed byte load at 0x13 → rsp_valid at T+3, rsp_rdata=0xFFFFFF88, rsp_err=0.
- Unsigned half load at 0x12 → 0x00008899. Signed byte load at 0x10 → 0xFFFFFFBB. Word load at 0x10 → 0x8899AABB.
- Byte store of 0x5A at 0x11:
  - mem_en high T+1 (read) and T+3 (write); mem_we high only at T+3
  - memory word becomes 0x88995ABB; rsp_valid at T+4
- Word store of 0x12345678 at 0x10 → single write at T+1, rsp_valid at T+2.
- Errors:
  - word load at 0x12, size 11, and byte load at 0x400 (WORDS=256) each give rsp_err=1 and rsp_rdata=0 at T+1
  - mem_en stays 0 throughout
- rst_n low during WAIT of a byte store → no write (word stays 0x8899AABB), no rsp_valid, req_ready=1 after the reset edge.
- Back-to-back: req_valid held high across two requests → req_ready low while busy, second request accepted on the edge after RESP, and both responses are correct.
